// File: rtl/xml_lang_id_dispatcher.sv
// xml_lang_id_dispatcher
// ----------------------
// Request dispatcher for the xmlCheckLanguageID HLS component. It takes
// language-string pointers from an upstream requester, runs the component's
// start/busy/done/stall call protocol one call at a time, and returns each
// 32-bit result with the requester's tag. It also counts completed responses.
//
// Optional feature (compile-time macro XML_LANG_DISP_WATCHDOG_EN):
//   When defined, a watchdog bounds each call. A call that runs too long is
//   answered with rsp_data=0 / rsp_timeout=1. The DRAIN state then discards the
//   component's late done. When undefined, WAIT waits indefinitely and
//   rsp_timeout is tied to 0.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. A response stays stable (rsp_*) while
// rsp_valid is high.
//
// Ports:
//   clock, resetn             clock, asynchronous active-low reset
//   req_valid/req_ready       request channel; req_ptr, req_tag payload
//   rsp_valid/rsp_ready       response channel; rsp_data, rsp_tag, rsp_timeout
//   comp_start/comp_busy      component call issue
//   comp_lang                 pointer argument driven to the component
//   comp_done/comp_stall      component return (stall holds done until WAIT/DRAIN)
//   comp_returndata           component result
//   stat_calls                completed responses, wraps at 2^16
//   idle                      FSM is in IDLE (state observation point)

module xml_lang_id_dispatcher #(
  parameter int PTR_W          = 64,
  parameter int RES_W          = 32,
  parameter int TAG_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PTR_W-1:0] req_ptr,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             comp_start,
  input  logic             comp_busy,
  output logic [PTR_W-1:0] comp_lang,
  input  logic             comp_done,
  output logic             comp_stall,
  input  logic [RES_W-1:0] comp_returndata,
  output logic [15:0]      stat_calls,
  output logic             idle
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0] lat_tag;
  logic             req_fire;
  logic             rsp_fire;
  logic             wd_expire;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

`ifdef XML_LANG_DISP_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            rsp_timeout_q;

  // Counter is cleared while issuing, so it starts at 0 on entry to WAIT.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT && !comp_done) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // A done in the expiry cycle takes priority; callers check comp_done first.
  assign wd_expire   = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_ISSUE;
      S_ISSUE: if (!comp_busy) state_nxt = S_WAIT;
      S_WAIT:  if (comp_done || wd_expire) state_nxt = S_HOLD;
      S_HOLD: begin
        if (rsp_ready) begin
          if (rsp_timeout)    state_nxt = S_DRAIN;
          else if (req_valid) state_nxt = S_ISSUE;  // pass-through request
          else                state_nxt = S_IDLE;
        end
      end
      S_DRAIN: if (comp_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    comp_start = 1'b0;
    comp_stall = 1'b1;
    rsp_valid  = 1'b0;
    idle       = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        idle      = 1'b1;
      end
      S_ISSUE: comp_start = 1'b1;
      S_WAIT:  comp_stall = 1'b0;
      S_HOLD: begin
        rsp_valid = 1'b1;
        // Accept the next request alongside the response unless a drain follows.
        req_ready = rsp_ready && !rsp_timeout;
      end
      S_DRAIN: comp_stall = 1'b0;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      comp_lang  <= '0;
      lat_tag    <= '0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      stat_calls <= '0;
    end else begin
      if (req_fire) begin
        comp_lang <= req_ptr;
        lat_tag   <= req_tag;
      end
      if (state == S_WAIT && (comp_done || wd_expire)) begin
        rsp_data <= comp_done ? comp_returndata : '0;
        rsp_tag  <= lat_tag;
      end
      if (rsp_fire) stat_calls <= stat_calls + 16'd1;
    end
  end

`ifdef XML_LANG_DISP_WATCHDOG_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_timeout_q <= 1'b0;
    end else if (state == S_WAIT && (comp_done || wd_expire)) begin
      rsp_timeout_q <= !comp_done;
    end
  end
`endif

endmodule
